// File: rtl/vga_timing_ctrl_if.sv
// Signal bundle between the VGA timing sequencer and its consumers
// (pixel output stage and line-fetch engine).
interface vga_timing_ctrl_if;
   logic        enable;
   logic [15:0] H_count_value;
   logic [15:0] V_count_value;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic        frame_start;
   logic        line_start;
   logic        fetch_req;
   logic [15:0] fetch_line;
   logic        fetch_ack;
   logic        underrun;

   modport master (
      input  enable, fetch_ack,
      output H_count_value, V_count_value, hsync, vsync, video_on,
             frame_start, line_start, fetch_req, fetch_line, underrun
   );

   modport slave (
      output enable, fetch_ack,
      input  H_count_value, V_count_value, hsync, vsync, video_on,
             frame_start, line_start, fetch_req, fetch_line, underrun
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: H/V position counters, registered sync/blanking decode
// and a one-line-ahead fetch request with underrun detection.
module vga_timing_ctrl #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic              clk_25MHz,
   input  logic              reset,
   vga_timing_ctrl_if.master bus
);

   localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] H_PRE  = 16'(H_ACTIVE - 1);
   localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE, REQ} fetch_state_t;

   fetch_state_t state_q, state_d;
   logic [15:0]  h_q, v_q, h_nxt, v_nxt, v_inc;
   logic [15:0]  line_q, line_d;
   logic         h_wrap, fetch_go, underrun_d;
   logic         hsync_q, vsync_q, video_on_q, frame_start_q, line_start_q, underrun_q;

   function automatic logic sync_level(input logic [15:0] pos,
                                       input logic [15:0] beg,
                                       input logic [15:0] fin);
      return (pos >= beg && pos < fin) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   endfunction

   always_comb begin
      h_wrap = bus.enable && (h_q == H_LAST);
      v_inc  = v_q + 16'd1;
      h_nxt  = h_q;
      v_nxt  = v_q;
      if (bus.enable) h_nxt = h_wrap ? 16'd0 : h_q + 16'd1;
      if (h_wrap)     v_nxt = (v_q == V_LAST) ? 16'd0 : v_inc;
   end

   // Outputs are decoded from the next counts so they line up with the counters.
   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         h_q           <= h_nxt;
         v_q           <= v_nxt;
         hsync_q       <= sync_level(h_nxt, HS_BEG, HS_END);
         vsync_q       <= sync_level(v_nxt, VS_BEG, VS_END);
         video_on_q    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         frame_start_q <= bus.enable && (h_nxt == 16'd0) && (v_nxt == 16'd0);
         line_start_q  <= bus.enable && (h_nxt == 16'd0) && (v_nxt < V_ACT);
      end
   end

   // The next line is fetched during this line's blanking; the last frame line
   // wraps to line 0, and lines entering vertical blanking request nothing.
   assign fetch_go = bus.enable && (h_q == H_PRE) && ((v_inc < V_ACT) || (v_q == V_LAST));

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      underrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (fetch_go) begin
               state_d = REQ;
               line_d  = (v_q == V_LAST) ? 16'd0 : v_inc;
            end
         end
         REQ: begin
            if (bus.fetch_ack) begin
               state_d = IDLE;
            end else if (h_wrap) begin
               state_d    = IDLE;
               underrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         line_q     <= 16'd0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         underrun_q <= underrun_d;
      end
   end

   assign bus.H_count_value = h_q;
   assign bus.V_count_value = v_q;
   assign bus.hsync         = hsync_q;
   assign bus.vsync         = vsync_q;
   assign bus.video_on      = video_on_q;
   assign bus.frame_start   = frame_start_q;
   assign bus.line_start    = line_start_q;
   assign bus.fetch_req     = (state_q == REQ);
   assign bus.fetch_line    = line_q;
   assign bus.underrun      = underrun_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced raster: per-cycle scoreboard against a
// reference model, table of fetch/ack scenarios, and frame-level aggregates.
module tb_vga_timing_ctrl;
   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 12, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int W  = HT - HA;

   logic clk_25MHz = 1'b0;
   logic reset     = 1'b1;
   always #20 clk_25MHz = ~clk_25MHz;

   vga_timing_ctrl_if bus();

   vga_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk_25MHz(clk_25MHz),
      .reset(reset),
      .bus(bus)
   );

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs, vs, von, fs, ls, req;
      logic [15:0] line;
      logic        und;
   } obs_t;

   typedef struct {
      int line;
      int ack_d;
      int exp_cycles;
      bit exp_und;
   } vec_t;

   vec_t vecs[6];
   obs_t sb[$];
   int   checks = 0, failures = 0;
   int   mh, mv, mline, age, ack_d;
   bit   mreq, mfs, mls, mund;

   function automatic obs_t model_obs();
      obs_t o;
      o.h    = 16'(mh);
      o.v    = 16'(mv);
      o.hs   = !(mh >= HA + HF && mh < HA + HF + HS);
      o.vs   = !(mv >= VA + VF && mv < VA + VF + VS);
      o.von  = (mh < HA) && (mv < VA);
      o.fs   = mfs;
      o.ls   = mls;
      o.req  = mreq;
      o.line = 16'(mline);
      o.und  = mund;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.h    = bus.H_count_value;
      o.v    = bus.V_count_value;
      o.hs   = bus.hsync;
      o.vs   = bus.vsync;
      o.von  = bus.video_on;
      o.fs   = bus.frame_start;
      o.ls   = bus.line_start;
      o.req  = bus.fetch_req;
      o.line = bus.fetch_line;
      o.und  = bus.underrun;
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got h=%0d v=%0d hs=%b vs=%b von=%b fs=%b ls=%b req=%b line=%0d und=%b | exp h=%0d v=%0d hs=%b vs=%b von=%b fs=%b ls=%b req=%b line=%0d und=%b",
                  name, got.h, got.v, got.hs, got.vs, got.von, got.fs, got.ls, got.req, got.line, got.und,
                  exp.h, exp.v, exp.hs, exp.vs, exp.von, exp.fs, exp.ls, exp.req, exp.line, exp.und);
      end
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      mh = HT - 1; mv = VT - 1; mreq = 0; mline = 0;
      mfs = 0; mls = 0; mund = 0; age = 0;
   endtask

   // Advance the model with the inputs currently driven, queue the expectation,
   // clock the DUT and compare on the falling edge.
   task automatic tick();
      bit wrap, prev;
      prev = mreq;
      mund = 0;
      wrap = bus.enable && (mh == HT - 1);
      if (mreq) begin
         if (bus.fetch_ack) mreq = 0;
         else if (wrap) begin mreq = 0; mund = 1; end
      end else if (bus.enable && mh == HA - 1 && (mv + 1 < VA || mv == VT - 1)) begin
         mreq  = 1;
         mline = (mv == VT - 1) ? 0 : mv + 1;
      end
      if (bus.enable) begin
         if (wrap) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else mh++;
      end
      mfs = bus.enable && mh == 0 && mv == 0;
      mls = bus.enable && mh == 0 && mv < VA;
      age = (mreq && prev) ? age + 1 : 0;
      sb.push_back(model_obs());
      @(posedge clk_25MHz);
      @(negedge clk_25MHz);
      check_obs("cycle", dut_obs(), sb.pop_front());
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         bus.fetch_ack = mreq && (ack_d >= 0) && (age == ack_d);
         tick();
      end
   endtask

   initial begin
      int von_cnt, hs_low, vs_low, fs_cnt, fs_first, fs_second;
      int guard, cnt, und, fl_cnt, hold_h;

      vecs[0] = '{line: 1,  ack_d: 2,     exp_cycles: 3, exp_und: 1'b0};
      vecs[1] = '{line: 3,  ack_d: 0,     exp_cycles: 1, exp_und: 1'b0};
      vecs[2] = '{line: 5,  ack_d: -1,    exp_cycles: W, exp_und: 1'b1};
      vecs[3] = '{line: 7,  ack_d: W - 1, exp_cycles: W, exp_und: 1'b0};
      vecs[4] = '{line: 10, ack_d: 5,     exp_cycles: 6, exp_und: 1'b0};
      vecs[5] = '{line: 0,  ack_d: 2,     exp_cycles: 3, exp_und: 1'b0};

      bus.enable    = 1'b0;
      bus.fetch_ack = 1'b0;
      ack_d         = 2;
      model_reset();
      repeat (2) @(negedge clk_25MHz);
      check_obs("reset_state", dut_obs(), model_obs());

      reset      = 1'b0;
      bus.enable = 1'b1;

      // Two full frames with a 3-cycle request/ack handshake.
      von_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
      for (int i = 0; i < 2 * FT; i++) begin
         run(1);
         if (bus.video_on) von_cnt++;
         if (!bus.hsync) hs_low++;
         if (!bus.vsync) vs_low++;
         if (bus.frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
         end
      end
      check("video_on_cycles", von_cnt, 2 * HA * VA);
      check("hsync_low_cycles", hs_low, 2 * VT * HS);
      check("vsync_low_cycles", vs_low, 2 * HT * VS);
      check("frame_start_count", fs_cnt, 2);
      check("frame_start_first", fs_first, 0);
      check("frame_start_period", fs_second - fs_first, FT);

      // Fetch/ack scenarios.
      foreach (vecs[k]) begin
         ack_d = vecs[k].ack_d;
         guard = 0;
         while (!(bus.fetch_req && bus.fetch_line == 16'(vecs[k].line)) && guard < 2 * FT) begin
            run(1);
            guard++;
         end
         check($sformatf("vec%0d_req_seen", k), int'(guard < 2 * FT), 1);
         cnt = 0; und = 0; guard = 0;
         while (guard < 2 * HT) begin
            if (bus.fetch_req) begin
               cnt++;
               run(1);
            end else begin
               und = int'(bus.underrun);
               break;
            end
            guard++;
         end
         check($sformatf("vec%0d_line%0d_req_cycles", k, vecs[k].line), cnt, vecs[k].exp_cycles);
         check($sformatf("vec%0d_line%0d_underrun", k, vecs[k].line), und, int'(vecs[k].exp_und));
      end

      // Freeze for 50 cycles mid-line; an ack while idle must be ignored.
      ack_d = 2;
      guard = 0;
      while (mh != 12 && guard < 2 * FT) begin run(1); guard++; end
      check("freeze_reach", int'(guard < 2 * FT), 1);
      hold_h        = mh;
      bus.enable    = 1'b0;
      bus.fetch_ack = 1'b1;
      fl_cnt        = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.frame_start || bus.line_start) fl_cnt++;
      end
      check("freeze_no_markers", fl_cnt, 0);
      bus.enable    = 1'b1;
      bus.fetch_ack = 1'b0;
      run(1);
      check("resume_h", int'(bus.H_count_value), hold_h + 1);

      // Asynchronous reset in the middle of an outstanding request.
      ack_d = -1;
      guard = 0;
      while (!(mreq && mv == 5 && mh == 20) && guard < 2 * FT) begin run(1); guard++; end
      check("midreq_reach", int'(guard < 2 * FT), 1);
      check("midreq_req_high", int'(bus.fetch_req), 1);
      bus.fetch_ack = 1'b0;
      #5 reset = 1'b1;
      model_reset();
      #1 check_obs("async_reset", dut_obs(), model_obs());
      @(negedge clk_25MHz);
      check_obs("reset_hold", dut_obs(), model_obs());
      reset = 1'b0;
      ack_d = 2;
      run(1);
      check("restart_frame_start", int'(bus.frame_start), 1);
      run(FT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
